// File: rtl/signed_addsub_accum_if.sv
// Operand/result bundle for signed_addsub_accum. The master drives operands
// and control; the slave (the arithmetic block) returns registered results.
interface signed_addsub_accum_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             clear_sticky;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             overflow_flag;
    logic             overflow_sticky;
    logic [WIDTH-1:0] acc_value;

    modport master (
        output enable, in_valid, op, inp1, inp2, clear_sticky,
        input  out_valid, sum, overflow_flag, overflow_sticky, acc_value
    );

    modport slave (
        input  enable, in_valid, op, inp1, inp2, clear_sticky,
        output out_valid, sum, overflow_flag, overflow_sticky, acc_value
    );
endinterface

// File: rtl/signed_addsub_accum.sv
// Registered two's-complement add/subtract/accumulate unit with optional
// saturation, one result per clock, per-result and sticky overflow flags.
module signed_addsub_accum #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    signed_addsub_accum_if.slave bus
);
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             accept;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   raw;
    logic             ovf;
    logic [WIDTH-1:0] result;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    logic             sticky_q;
    logic [WIDTH-1:0] acc_q;

    // Reset priority is handled in the register block, so accept ignores it here.
    assign accept = bus.enable & bus.in_valid;

    // Sign-extend by one bit so the carry into bit WIDTH exposes overflow,
    // including the A - (most negative) corner.
    assign a_ext   = {bus.inp1[WIDTH-1], bus.inp1};
    assign b_ext   = {bus.inp2[WIDTH-1], bus.inp2};
    assign acc_ext = {acc_q[WIDTH-1], acc_q};

    // Raw wide result, overflow detection and wrap/saturate selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        raw    = a_ext;
        ovf    = 1'b0;
        result = bus.inp1;
        case (op_e'(bus.op))
            OP_ADD:  raw = a_ext + b_ext;
            OP_SUB:  raw = a_ext - b_ext;
            OP_ACC:  raw = acc_ext + a_ext;
            OP_LOAD: raw = a_ext;
            default: raw = a_ext;
        endcase
        if (op_e'(bus.op) != OP_LOAD) begin
            ovf = raw[WIDTH] ^ raw[WIDTH-1];
        end
        result = raw[WIDTH-1:0];
        if (SATURATE && ovf) begin
            result = raw[WIDTH] ? MIN_NEG : MAX_POS;
        end
    end

    // Result, flag and accumulator registers; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                sum_q <= result;
                ovf_q <= ovf;
                if (op_e'(bus.op) == OP_ACC) begin
                    acc_q <= result;
                end else if (op_e'(bus.op) == OP_LOAD) begin
                    acc_q <= bus.inp1;
                end
            end
            // A new overflow outranks a clear in the same cycle.
            if (accept && ovf) begin
                sticky_q <= 1'b1;
            end else if (bus.clear_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.sum             = sum_q;
    assign bus.overflow_flag   = ovf_q;
    assign bus.overflow_sticky = sticky_q;
    assign bus.acc_value       = acc_q;
endmodule

// File: doc/signed_addsub_accum.md
Name: signed_addsub_accum

Overview:
Parametrised two's-complement adder/subtractor/accumulator. It is the registered, width-generic successor of the team's 8-bit signed adder with overflow flag. It adds subtract and accumulate modes, optional saturation, a valid handshake and a sticky overflow status. It sits in the datapath wherever signed sums must be produced one per clock with overflow tracking.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2), two's-complement signed.
SATURATE, 0, 0 = wrap on overflow; 1 = clamp to most-positive/most-negative value.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; 0 = no operation accepted
in_valid  input  1  operands/op valid this cycle
op  input  2  00 add (inp1+inp2), 01 sub (inp1-inp2), 10 accumulate (acc+inp1), 11 load acc (acc=inp1)
inp1  input  WIDTH  signed operand A
inp2  input  WIDTH  signed operand B (ignored for op 10/11)
clear_sticky  input  1  clears overflow_sticky
out_valid  output  1  sum/overflow_flag valid, one-cycle pulse per accepted op
sum  output  WIDTH  registered signed result
overflow_flag  output  1  overflow of the result currently on sum
overflow_sticky  output  1  set by any overflow since reset/clear
acc_value  output  WIDTH  current accumulator register

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset.
- Reset: sum=0, acc_value=0, out_valid=0, overflow_flag=0, overflow_sticky=0. Reset overrides every other input in the same cycle, including reset mid-accumulate.
- accept = enable & in_valid & ~reset.
- Latency is 1 cycle: an op accepted at edge N drives sum/overflow_flag/out_valid after edge N. Throughput is one op per cycle with no stalls.
- No accept: out_valid<=0. sum, overflow_flag and acc_value hold.
- Arithmetic: operands are sign-extended to WIDTH+1 bits.
  - Raw result r = A+B (00), A-B (01), or acc+A (10).
  - Overflow ovf = r[WIDTH] != r[WIDTH-1].
  - op 11: r = A, ovf = 0.
- Result select:
  - SATURATE=0: sum = r[WIDTH-1:0] (wrap).
  - SATURATE=1 and ovf: r[WIDTH]=0 gives 2^(WIDTH-1)-1; r[WIDTH]=1 gives -2^(WIDTH-1).
  - Otherwise sum = r[WIDTH-1:0].
- Accumulator: updated only on accepted op 10 (gets the selected, i.e. wrapped or saturated, result) or op 11 (gets inp1). Ops 00/01 leave acc unchanged.
- overflow_flag <= ovf on accept. Holds otherwise.
- overflow_sticky priority: reset clears; then accept with ovf sets; then clear_sticky clears; otherwise holds. Simultaneous overflow and clear_sticky leaves sticky = 1.
- Subtract edge case: A - (-2^(WIDTH-1)) is computed in WIDTH+1 bits, so ovf is correct for A >= 0.
- All outputs are registers; no combinational input-to-output paths.

Test Plan:
1. WIDTH=8. Reset 1 cycle, then accept op 00, inp1=1, inp2=-1 (0xFF) -> next cycle sum=0x00, overflow_flag=0, out_valid=1 for exactly one cycle.
2. op 00, 0x7F+0x01 -> SATURATE=0: sum=0x80, overflow_flag=1, overflow_sticky=1. SATURATE=1: sum=0x7F, flags as before. Then 0x80+0xFF -> wrap 0x7F / sat 0x80, overflow_flag=1.
3. op 01, inp1=0, inp2=0x80 -> overflow_flag=1; sum=0x80 (wrap) or 0x7F (sat). Then op 01, 0xFF-0x80 -> sum=0x7F, overflow_flag=0.
4. Back-to-back ops: op 11 inp1=100, then op 10 inp1=20, then op 10 inp1=10 -> acc_value 100, 120, then 0x82 with ovf=1 (wrap) or 0x7F (sat). Then op 10 inp1=-1 -> 0x81 (wrap) / 0x7E (sat). out_valid is high on each of the 4 consecutive cycles.
5. enable=0 with in_valid=1 for 3 cycles -> out_valid=0; sum, acc_value and overflow_flag unchanged. Overflowing op together with clear_sticky=1 -> sticky stays 1. Next cycle clear_sticky alone -> sticky=0.
6. Reset asserted mid-accumulate, with a valid op in the same cycle -> after the edge acc_value=0, sum=0, out_valid=0, both flags 0. The op is discarded.
